// File: rtl/riego_scheduler.sv
// Round-robin time-slot scheduler sharing one pump among four irrigation valves.
// One valve is granted at a time for SLOT_CYCLES, with GAP_CYCLES of settle between grants.
module riego_scheduler #(
  parameter int SLOT_CYCLES = 16,
  parameter int GAP_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       level_ok,
  input  logic       err_in,
  output logic [3:0] grant,
  output logic [1:0] G1,
  output logic [1:0] G2,
  output logic       busy,
  output logic       fault,
  output logic [7:0] slots_done,
  output logic [1:0] dbg_state
);

  localparam int MAXC = (SLOT_CYCLES > GAP_CYCLES) ? SLOT_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(MAXC + 1);
  localparam logic [TW-1:0] SLOT_LOAD = TW'(SLOT_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [1:0]    ptr, ptr_n;
  logic [1:0]    win, win_n;
  logic [3:0]    grant_n;
  logic [7:0]    done_n;
  logic [1:0]    pick, idx;
  logic          interlock, any_req;

  // req is a level request: a valve keeps watering only while its bit stays high.
  assign interlock = !level_ok || err_in;
  assign any_req   = |req;

  // Lowest offset from ptr wins, so the loop runs from the far end down.
  always_comb begin
    pick = ptr;
    idx  = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) pick = idx;
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    ptr_n   = ptr;
    win_n   = win;
    grant_n = grant;
    done_n  = slots_done;
    if (timer != '0) timer_n = timer - 1'b1;
    case (state)
      S_IDLE: begin
        if (interlock) begin
          state_n = S_FAULT;
          timer_n = '0;
        end else if (any_req) begin
          state_n = S_GRANT;
          timer_n = SLOT_LOAD;
          win_n   = pick;
          grant_n = 4'(1) << pick;
        end
      end
      S_GRANT: begin
        if (interlock) begin
          state_n = S_FAULT;
          timer_n = '0;
          grant_n = '0;
        end else if (!req[win]) begin
          state_n = S_GAP;
          timer_n = GAP_LOAD;
          grant_n = '0;
          ptr_n   = win + 2'd1;
        end else if (timer == '0) begin
          state_n = S_GAP;
          timer_n = GAP_LOAD;
          grant_n = '0;
          ptr_n   = win + 2'd1;
          if (slots_done != 8'hFF) done_n = slots_done + 8'd1;
        end
      end
      S_GAP: begin
        if (interlock) begin
          state_n = S_FAULT;
          timer_n = '0;
        end else if (timer == '0) begin
          if (any_req) begin
            state_n = S_GRANT;
            timer_n = SLOT_LOAD;
            win_n   = pick;
            grant_n = 4'(1) << pick;
          end else begin
            state_n = S_IDLE;
            timer_n = '0;
          end
        end
      end
      S_FAULT: begin
        // Leaving a fault always passes through a full settle gap.
        if (!interlock) begin
          state_n = S_GAP;
          timer_n = GAP_LOAD;
        end
      end
      default: begin
        state_n = S_IDLE;
        timer_n = '0;
        grant_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      timer      <= '0;
      ptr        <= '0;
      win        <= '0;
      grant      <= '0;
      slots_done <= '0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      ptr        <= ptr_n;
      win        <= win_n;
      grant      <= grant_n;
      slots_done <= done_n;
    end
  end

  assign G1        = grant[1:0];
  assign G2        = grant[3:2];
  assign busy      = (state == S_GRANT);
  assign fault     = (state == S_FAULT);
  assign dbg_state = state;

endmodule

// File: tb/tb_riego_scheduler.sv
// Directed bench for riego_scheduler: cycle model compared every cycle plus literal spot checks.
module tb_riego_scheduler;

  localparam int SLOT = 4;
  localparam int GAP  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req = 4'b0;
  logic       level_ok = 1'b1;
  logic       err_in = 1'b0;
  logic [3:0] grant;
  logic [1:0] G1, G2;
  logic       busy, fault;
  logic [7:0] slots_done;
  logic [1:0] dbg_state;

  int n_pass = 0;
  int n_total = 0;
  logic [3:0] exp_q[$];

  riego_scheduler #(.SLOT_CYCLES(SLOT), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .req(req), .level_ok(level_ok), .err_in(err_in),
    .grant(grant), .G1(G1), .G2(G2), .busy(busy), .fault(fault),
    .slots_done(slots_done), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // model: which valve is watering, how long, how much gap is left, fault flag
  int m_cur = -1;
  int m_age = 0;
  int m_gap = 0;
  bit m_fault = 0;
  int m_ptr = 0;
  int m_done = 0;

  task automatic m_try_grant();
    for (int k = 0; k < 4; k++) begin
      if (req[(m_ptr + k) % 4]) begin
        m_cur = (m_ptr + k) % 4;
        m_age = 0;
        return;
      end
    end
  endtask

  task automatic m_step();
    bit il;
    il = !level_ok || err_in;
    if (m_fault) begin
      if (!il) begin m_fault = 0; m_gap = GAP; end
    end else if (m_cur >= 0) begin
      if (il) begin
        m_cur = -1; m_fault = 1;
      end else if (!req[m_cur]) begin
        m_ptr = (m_cur + 1) % 4; m_cur = -1; m_gap = GAP;
      end else begin
        m_age++;
        if (m_age == SLOT) begin
          if (m_done < 255) m_done++;
          m_ptr = (m_cur + 1) % 4; m_cur = -1; m_gap = GAP;
        end
      end
    end else if (m_gap > 0) begin
      if (il) begin
        m_gap = 0; m_fault = 1;
      end else begin
        m_gap--;
        if (m_gap == 0) m_try_grant();
      end
    end else begin
      if (il) m_fault = 1;
      else m_try_grant();
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cur = -1; m_age = 0; m_gap = 0; m_fault = 0; m_ptr = 0; m_done = 0;
    end else begin
      m_step();
    end
  end

  function automatic logic [3:0] m_grant();
    return (m_cur >= 0) ? 4'(1 << m_cur) : 4'b0;
  endfunction

  // scoreboard compare, every cycle away from the active edge
  always @(negedge clk) begin
    if (reset) begin
      chk("grant", {4'b0, grant}, {4'b0, m_grant()});
      chk("G1", {6'b0, G1}, {6'b0, (m_cur == 0) ? 2'b01 : (m_cur == 1) ? 2'b10 : 2'b00});
      chk("G2", {6'b0, G2}, {6'b0, (m_cur == 2) ? 2'b01 : (m_cur == 3) ? 2'b10 : 2'b00});
      chk("busy", {7'b0, busy}, {7'b0, m_cur >= 0});
      chk("fault", {7'b0, fault}, {7'b0, m_fault});
      chk("slots_done", slots_done, 8'(m_done));
      chk("onehot", 8'($countones(grant) <= 1), 8'd1);
    end
  end

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #1;
    chk("rst_grant", {4'b0, grant}, 8'h00);
    chk("rst_busy", {7'b0, busy}, 8'h00);
    chk("rst_fault", {7'b0, fault}, 8'h00);
    chk("rst_done", slots_done, 8'h00);
    cycles(2);
    reset = 1'b1;

    // single request
    cycles(1); req = 4'b0001;
    cycles(1); chk("single_g", {4'b0, grant}, 8'h01); chk("single_G1", {6'b0, G1}, 8'h01);
    cycles(4); chk("single_gap", {4'b0, grant}, 8'h00); chk("single_done1", slots_done, 8'd1);
    cycles(2); chk("single_regrant", {4'b0, grant}, 8'h01);
    cycles(6); chk("single_done2", slots_done, 8'd2);
    req = 4'b0000;
    cycles(3);

    // round robin
    do_reset();
    req = 4'b1111;
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    cycles(1);
    while (exp_q.size() > 0) begin
      if (exp_q.size() == 2) chk("rr_G2", {6'b0, G2}, 8'h02);
      chk("rr_order", {4'b0, grant}, {4'b0, exp_q.pop_front()});
      if (exp_q.size() > 0) cycles(6);
    end
    chk("rr_done", slots_done, 8'd4);
    req = 4'b0000;
    cycles(3);

    // early release
    do_reset();
    req = 4'b0100;
    cycles(2); chk("early_g", {4'b0, grant}, 8'h04);
    req = 4'b0000;
    cycles(1); chk("early_low", {4'b0, grant}, 8'h00); chk("early_done", slots_done, 8'd0);
    cycles(2); chk("early_idle", {7'b0, busy}, 8'h00);

    // level interlock
    do_reset();
    req = 4'b0011;
    cycles(2); level_ok = 1'b0;
    cycles(1); chk("lvl_fault", {7'b0, fault}, 8'h01); chk("lvl_grant", {4'b0, grant}, 8'h00);
    cycles(2); level_ok = 1'b1;
    cycles(1); chk("lvl_gap", {7'b0, fault}, 8'h00);
    cycles(2); chk("lvl_retry", {4'b0, grant}, 8'h01);
    req = 4'b0000;
    cycles(4);

    // error interlock from idle
    req = 4'b1000; err_in = 1'b1;
    cycles(1); chk("err_fault", {7'b0, fault}, 8'h01); chk("err_grant", {4'b0, grant}, 8'h00);
    cycles(3); err_in = 1'b0;
    cycles(2); chk("err_gap", {4'b0, grant}, 8'h00);
    cycles(1); chk("err_grant8", {4'b0, grant}, 8'h08); chk("err_G2", {6'b0, G2}, 8'h02);
    req = 4'b0000;
    cycles(4);

    // slots_done saturation
    do_reset();
    req = 4'b0001;
    cycles(260 * (SLOT + GAP));
    chk("sat_done", slots_done, 8'd255);

    // reset in the middle of a 0010 slot
    req = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (grant == 4'b0010) break;
    end
    chk("wait_g2", {4'b0, grant}, 8'h02);
    reset = 1'b0;
    #1;
    chk("mid_grant", {4'b0, grant}, 8'h00);
    chk("mid_G1", {6'b0, G1}, 8'h00);
    chk("mid_G2", {6'b0, G2}, 8'h00);
    chk("mid_busy", {7'b0, busy}, 8'h00);
    chk("mid_fault", {7'b0, fault}, 8'h00);
    chk("mid_done", slots_done, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    cycles(1); chk("post_grant", {4'b0, grant}, 8'h02); chk("post_G1", {6'b0, G1}, 8'h02);
    cycles(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
